// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: one-hot state encodings, default bus timing and checksum helper.
// Used by both the responder and the host-side block.
package dht11_pkg;

  typedef enum logic [7:0] {
    StIdle      = 8'h01,
    StStartLow  = 8'h02,
    StRespDelay = 8'h04,
    StAckLow    = 8'h08,
    StAckHigh   = 8'h10,
    StBitLow    = 8'h20,
    StBitHigh   = 8'h40,
    StEndLow    = 8'h80
  } dht11_state_e;

  localparam int unsigned CLK_PER_US_DEF    = 100;
  localparam int unsigned START_MIN_US_DEF  = 18000;
  localparam int unsigned RESP_DELAY_US_DEF = 30;
  localparam int unsigned ACK_LOW_US_DEF    = 80;
  localparam int unsigned ACK_HIGH_US_DEF   = 80;
  localparam int unsigned BIT_LOW_US_DEF    = 50;
  localparam int unsigned BIT0_HIGH_US_DEF  = 26;
  localparam int unsigned BIT1_HIGH_US_DEF  = 70;
  localparam int unsigned END_LOW_US_DEF    = 50;

  localparam int unsigned US_CNT_W   = 16;
  localparam int unsigned FRAME_BITS = 40;

  function automatic logic [7:0] dht11_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                input logic [7:0] b2, input logic [7:0] b3);
    return b0 + b1 + b2 + b3;
  endfunction

endpackage

// File: rtl/usec_tick.sv
// Free-running divider producing a one-cycle tick every CLK_PER_US clocks.
// A synchronous clear restarts the period so timed states start on a clean boundary.
module usec_tick #(
  parameter int unsigned CLK_PER_US = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(CLK_PER_US - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: validates a host start pulse, then drives the ack and a
// 40-bit frame (payload snapshot plus checksum) onto the open-drain bus.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US    = CLK_PER_US_DEF,
  parameter int unsigned START_MIN_US  = START_MIN_US_DEF,
  parameter int unsigned RESP_DELAY_US = RESP_DELAY_US_DEF,
  parameter int unsigned ACK_LOW_US    = ACK_LOW_US_DEF,
  parameter int unsigned ACK_HIGH_US   = ACK_HIGH_US_DEF,
  parameter int unsigned BIT_LOW_US    = BIT_LOW_US_DEF,
  parameter int unsigned BIT0_HIGH_US  = BIT0_HIGH_US_DEF,
  parameter int unsigned BIT1_HIGH_US  = BIT1_HIGH_US_DEF,
  parameter int unsigned END_LOW_US    = END_LOW_US_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  inout  wire        dht11_data,
  input  logic       enable,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic       start_err,
  output logic [7:0] state_dbg
);

  dht11_state_e state_q, state_d;

  logic                  data_meta_q, data_sync_q;
  logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d;
  logic [5:0]            bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  frame_done_q, frame_done_d;
  logic                  start_err_q, start_err_d;

  logic                  tick;
  logic                  state_chg;
  logic [US_CNT_W-1:0]   dur_m1;
  logic                  expire;
  logic                  cur_bit;
  logic                  drive_low;

  assign state_chg = (state_d != state_q);

  usec_tick #(
    .CLK_PER_US(CLK_PER_US)
  ) u_usec_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_chg),
    .tick   (tick)
  );

  assign cur_bit = frame_q[6'(FRAME_BITS - 1) - bit_idx_q];

  // Last-microsecond value of the current timed state; expire fires on its final tick.
  always_comb begin
    dur_m1 = '0;
    unique case (state_q)
      StRespDelay: dur_m1 = US_CNT_W'(RESP_DELAY_US - 1);
      StAckLow:    dur_m1 = US_CNT_W'(ACK_LOW_US - 1);
      StAckHigh:   dur_m1 = US_CNT_W'(ACK_HIGH_US - 1);
      StBitLow:    dur_m1 = US_CNT_W'(BIT_LOW_US - 1);
      StBitHigh:   dur_m1 = cur_bit ? US_CNT_W'(BIT1_HIGH_US - 1) : US_CNT_W'(BIT0_HIGH_US - 1);
      StEndLow:    dur_m1 = US_CNT_W'(END_LOW_US - 1);
      default:     dur_m1 = '0;
    endcase
  end

  assign expire = tick && (us_cnt_q == dur_m1);

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && !data_sync_q) begin
          state_d = StStartLow;
        end
      end
      StStartLow: begin
        if (data_sync_q) begin
          if (us_cnt_q >= US_CNT_W'(START_MIN_US)) begin
            frame_d = {hum_int, hum_dec, tmp_int, tmp_dec,
                       dht11_checksum(hum_int, hum_dec, tmp_int, tmp_dec)};
            state_d = StRespDelay;
          end else begin
            start_err_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StRespDelay: begin
        if (expire) state_d = StAckLow;
      end
      StAckLow: begin
        if (expire) state_d = StAckHigh;
      end
      StAckHigh: begin
        if (expire) begin
          state_d   = StBitLow;
          bit_idx_d = '0;
        end
      end
      StBitLow: begin
        if (expire) state_d = StBitHigh;
      end
      StBitHigh: begin
        if (expire) begin
          if (bit_idx_q == 6'(FRAME_BITS - 1)) begin
            state_d   = StEndLow;
            bit_idx_d = '0;
          end else begin
            state_d   = StBitLow;
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end
      end
      StEndLow: begin
        if (expire) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter restarts on every state change and saturates so long start pulses cannot wrap.
  always_comb begin
    us_cnt_d = us_cnt_q;
    if (state_chg) begin
      us_cnt_d = '0;
    end else if (tick && (us_cnt_q != '1)) begin
      us_cnt_d = us_cnt_q + US_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      data_meta_q  <= 1'b1;
      data_sync_q  <= 1'b1;
      us_cnt_q     <= '0;
      bit_idx_q    <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_meta_q  <= dht11_data;
      data_sync_q  <= data_meta_q;
      us_cnt_q     <= us_cnt_d;
      bit_idx_q    <= bit_idx_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  // Drive decoded straight from the state register so reset releases the bus immediately.
  assign drive_low  = (state_q == StAckLow) || (state_q == StBitLow) || (state_q == StEndLow);
  assign dht11_data = drive_low ? 1'b0 : 1'bz;

  assign busy       = !((state_q == StIdle) || (state_q == StStartLow));
  assign frame_done = frame_done_q;
  assign start_err  = start_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: decodes bus widths at negedges and checks frames,
// start errors, enable gating, payload snapshotting and mid-frame reset.
module tb_dht11_responder;

  // Scaled timing: 2 clocks per us, 180 us minimum start; host "20 ms" start is 200 us.
  localparam int unsigned CPU       = 2;
  localparam int unsigned START_MIN = 180;
  localparam int          MAXC      = 4000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       host_low;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
  wire        dht11_data;
  logic       busy, frame_done, start_err;
  logic [7:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0, se_cnt = 0, busy_cnt = 0, drv_cnt = 0;

  assign dht11_data = host_low ? 1'b0 : 1'bz;
  pullup (dht11_data);

  always #5 clk = ~clk;

  dht11_responder #(
    .CLK_PER_US  (CPU),
    .START_MIN_US(START_MIN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dht11_data(dht11_data),
    .enable    (enable),
    .hum_int   (hum_int),
    .hum_dec   (hum_dec),
    .tmp_int   (tmp_int),
    .tmp_dec   (tmp_dec),
    .busy      (busy),
    .frame_done(frame_done),
    .start_err (start_err),
    .state_dbg (state_dbg)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (start_err === 1'b1) se_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (dht11_data === 1'b0 && !host_low) drv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Counts negedge samples at level lvl; stops on the first differing sample (consumed).
  task automatic measure(input logic lvl, input bit first, output int n);
    n = first ? 1 : 0;
    while (n < MAXC) begin
      @(negedge clk);
      if (dht11_data !== lvl) return;
      n++;
    end
  endtask

  task automatic host_start(input int low_us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low_us * CPU) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [39:0] exp_bits, input int chg_bit);
    int resp, ack_lo, ack_hi, end_lo, lo, hi, fd0;
    logic [39:0] bits;
    bit ok;
    fd0 = fd_cnt;
    ok = 1'b1;
    bits = '0;
    measure(1'b1, 1'b0, resp);
    measure(1'b0, 1'b1, ack_lo);
    measure(1'b1, 1'b1, ack_hi);
    for (int i = 0; i < 40; i++) begin
      if (i == chg_bit) begin
        hum_int = 8'hAA; hum_dec = 8'hAA; tmp_int = 8'hAA; tmp_dec = 8'hAA;
      end
      measure(1'b0, 1'b1, lo);
      measure(1'b1, 1'b1, hi);
      if (lo != 100) ok = 1'b0;
      if (hi != 52 && hi != 140) ok = 1'b0;
      bits = {bits[38:0], (hi == 140)};
      if (lo >= MAXC || hi >= MAXC) break;
    end
    measure(1'b0, 1'b1, end_lo);
    repeat (4) @(negedge clk);
    check({tag, " resp_high"}, resp, 62);
    check({tag, " ack_low"}, ack_lo, 160);
    check({tag, " ack_high"}, ack_hi, 160);
    check({tag, " bit_widths"}, {31'd0, ok}, 1);
    check({tag, " hum_int"}, bits[39:32], exp_bits[39:32]);
    check({tag, " hum_dec"}, bits[31:24], exp_bits[31:24]);
    check({tag, " tmp_int"}, bits[23:16], exp_bits[23:16]);
    check({tag, " tmp_dec"}, bits[15:8], exp_bits[15:8]);
    check({tag, " checksum"}, bits[7:0], exp_bits[7:0]);
    check({tag, " end_low"}, end_lo, 100);
    check({tag, " frame_done"}, fd_cnt - fd0, 1);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " state_after"}, state_dbg, 8'h01);
  endtask

  initial begin
    int se0, busy0, drv0, fd0, resp;
    reset_n = 1'b0;
    enable = 1'b1;
    host_low = 1'b0;
    hum_int = 8'h37; hum_dec = 8'h00; tmp_int = 8'h19; tmp_dec = 8'h00;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst start_err", start_err, 0);
    check("rst state", state_dbg, 8'h01);
    check("rst bus", dht11_data, 1);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal frame
    @(negedge clk);
    host_low = 1'b1;
    repeat (20) @(negedge clk);
    check("start_low state", state_dbg, 8'h02);
    repeat (200 * CPU - 20) @(negedge clk);
    host_low = 1'b0;
    check_frame("frameA", 40'h37_00_19_00_50, -1);

    // Short start
    se0 = se_cnt; busy0 = busy_cnt; drv0 = drv_cnt;
    host_start(50);
    repeat (20) @(negedge clk);
    check("short start_err", se_cnt - se0, 1);
    check("short busy", busy_cnt - busy0, 0);
    check("short bus_driven", drv_cnt - drv0, 0);
    check("short state", state_dbg, 8'h01);

    // Enable low
    enable = 1'b0;
    se0 = se_cnt; busy0 = busy_cnt; drv0 = drv_cnt; fd0 = fd_cnt;
    @(negedge clk);
    host_low = 1'b1;
    repeat (100) @(negedge clk);
    check("dis state", state_dbg, 8'h01);
    repeat (200 * CPU - 100) @(negedge clk);
    host_low = 1'b0;
    repeat (200) @(negedge clk);
    check("dis start_err", se_cnt - se0, 0);
    check("dis busy", busy_cnt - busy0, 0);
    check("dis bus_driven", drv_cnt - drv0, 0);
    check("dis frame_done", fd_cnt - fd0, 0);
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // Payload changes during bit 3 must not affect the frame
    hum_int = 8'h12; hum_dec = 8'h34; tmp_int = 8'h56; tmp_dec = 8'h78;
    host_start(200);
    check_frame("snap", 40'h12_34_56_78_14, 3);

    // All-ones payload
    hum_int = 8'hFF; hum_dec = 8'hFF; tmp_int = 8'hFF; tmp_dec = 8'hFF;
    host_start(200);
    check_frame("ones", 40'hFF_FF_FF_FF_FC, -1);

    // Reset during ACK_LOW
    hum_int = 8'h37; hum_dec = 8'h00; tmp_int = 8'h19; tmp_dec = 8'h00;
    host_start(200);
    measure(1'b1, 1'b0, resp);
    check("rst_mid resp_high", resp, 62);
    repeat (10) @(negedge clk);
    check("rst_mid ack_state", state_dbg, 8'h08);
    check("rst_mid ack_driven", dht11_data, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid bus_released", dht11_data, 1);
    check("rst_mid busy", busy, 0);
    check("rst_mid state", state_dbg, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid idle_bus", dht11_data, 1);
    host_start(200);
    check_frame("after_rst", 40'h37_00_19_00_50, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
